// File: rtl/led_sequencer.sv
// Command-driven LED pattern sequencer: BLINK, CHASE or COUNT patterns advanced on a
// programmable tick, for a fixed number of steps or forever.
module led_sequencer #(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned STEPS_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic [STEPS_W-1:0]  cmd_steps,
  output logic [4:0]          leds,
  output logic                tick_out,
  output logic                done,
  output logic                busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  localparam logic [1:0] ModeOff   = 2'd0;
  localparam logic [1:0] ModeBlink = 2'd1;
  localparam logic [1:0] ModeChase = 2'd2;
  localparam logic [1:0] ModeCount = 2'd3;

  state_e                state;
  logic [1:0]            mode_q;
  logic [PERIOD_W-1:0]   period_q;
  logic [PERIOD_W-1:0]   prescaler;
  logic [STEPS_W-1:0]    step_cnt;
  logic                  finite_q;
  logic                  accept;
  logic                  tick_hit;
  logic [4:0]            init_leds;
  logic [4:0]            next_leds;

  assign cmd_ready = (state != StLoad);
  assign busy      = (state != StIdle);
  assign accept    = cmd_valid && cmd_ready;
  assign tick_hit  = (state == StRun) && (prescaler == period_q);

  always_comb begin
    init_leds = 5'b00000;
    next_leds = leds;
    unique case (mode_q)
      ModeOff:   begin init_leds = 5'b00000; next_leds = leds; end
      ModeBlink: begin init_leds = 5'b00000; next_leds = ~leds; end
      ModeChase: begin init_leds = 5'b00001; next_leds = {leds[3:0], leds[4]}; end
      ModeCount: begin init_leds = 5'b00000; next_leds = leds + 5'd1; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      mode_q    <= ModeOff;
      period_q  <= '0;
      prescaler <= '0;
      step_cnt  <= '0;
      finite_q  <= 1'b0;
      leds      <= 5'b00000;
      tick_out  <= 1'b0;
      done      <= 1'b0;
    end else begin
      tick_out <= 1'b0;
      done     <= 1'b0;
      // A newly accepted command takes priority over any tick due on this edge.
      if (accept) begin
        prescaler <= '0;
        if (cmd_mode == ModeOff) begin
          state    <= StIdle;
          leds     <= 5'b00000;
          step_cnt <= '0;
          finite_q <= 1'b0;
        end else begin
          state    <= StLoad;
          mode_q   <= cmd_mode;
          period_q <= cmd_period;
          step_cnt <= cmd_steps;
          finite_q <= (cmd_steps != '0);
        end
      end else begin
        unique case (state)
          StIdle: ;
          StLoad: begin
            state     <= StRun;
            prescaler <= '0;
            leds      <= init_leds;
          end
          StRun: begin
            if (tick_hit) begin
              prescaler <= '0;
              leds      <= next_leds;
              tick_out  <= 1'b1;
              if (finite_q) begin
                step_cnt <= step_cnt - STEPS_W'(1);
                if (step_cnt == STEPS_W'(1)) begin
                  state <= StIdle;
                  done  <= 1'b1;
                end
              end
            end else begin
              prescaler <= prescaler + PERIOD_W'(1);
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: a closed-form pattern model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_led_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic [15:0] cmd_period;
  logic [7:0]  cmd_steps;
  logic [4:0]  leds;
  logic        tick_out;
  logic        done;
  logic        busy;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  led_sequencer #(.PERIOD_W(16), .STEPS_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_period (cmd_period),
    .cmd_steps  (cmd_steps),
    .leds       (leds),
    .tick_out   (tick_out),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pattern after k ticks of a run, straight from the mode definitions.
  function automatic logic [4:0] pat(input logic [1:0] m, input int k);
    logic [4:0] v;
    v = 5'b00000;
    case (m)
      2'd1: v = (k % 2 == 1) ? 5'b11111 : 5'b00000;
      2'd2: v = 5'b00001 << (k % 5);
      2'd3: v = 5'(k % 32);
      default: v = 5'b00000;
    endcase
    return v;
  endfunction

  // Model: phase 0=idle, 1=load, 2=run; ticks counted from cycles since run entry.
  int         m_phase;
  logic [1:0] m_mode;
  int         m_period;
  int         m_steps;
  int         m_cyc;
  int         m_ticks;
  logic [4:0] exp_leds;
  logic       exp_tick;
  logic       exp_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  <= 0;
      m_mode   <= 2'd0;
      m_period <= 0;
      m_steps  <= 0;
      m_cyc    <= 0;
      m_ticks  <= 0;
      exp_leds <= 5'b00000;
      exp_tick <= 1'b0;
      exp_done <= 1'b0;
    end else begin
      exp_tick <= 1'b0;
      exp_done <= 1'b0;
      if (cmd_valid && m_phase != 1) begin
        if (cmd_mode == 2'd0) begin
          m_phase  <= 0;
          exp_leds <= 5'b00000;
        end else begin
          m_phase  <= 1;
          m_mode   <= cmd_mode;
          m_period <= int'(cmd_period);
          m_steps  <= int'(cmd_steps);
        end
      end else if (m_phase == 1) begin
        m_phase  <= 2;
        m_cyc    <= 0;
        m_ticks  <= 0;
        exp_leds <= pat(m_mode, 0);
      end else if (m_phase == 2) begin
        m_cyc <= m_cyc + 1;
        if ((m_cyc + 1) % (m_period + 1) == 0) begin
          m_ticks  <= m_ticks + 1;
          exp_leds <= pat(m_mode, m_ticks + 1);
          exp_tick <= 1'b1;
          if (m_steps != 0 && m_ticks + 1 == m_steps) begin
            m_phase  <= 0;
            exp_done <= 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_leds", int'(leds), int'(exp_leds));
      chk("model_tick", int'(tick_out), int'(exp_tick));
      chk("model_done", int'(done), int'(exp_done));
      chk("model_busy", int'(busy), (m_phase != 0) ? 1 : 0);
      chk("model_ready", int'(cmd_ready), (m_phase != 1) ? 1 : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [1:0] m, input int p, input int s);
    cmd_valid  = 1'b1;
    cmd_mode   = m;
    cmd_period = 16'(p);
    cmd_steps  = 8'(s);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_mode   = 2'd0;
    cmd_period = 16'd0;
    cmd_steps  = 8'd0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_leds", int'(leds), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    started = 1'b1;
    cyc(1);

    // CHASE, period 3, 6 steps.
    send(2'd2, 3, 6);
    cyc(1);
    chk("chase_init", int'(leds), 5'b00001);
    cyc(4);
    chk("chase_first", int'(leds), 5'b00010);
    chk("chase_first_tick", int'(tick_out), 1);
    cyc(20);
    chk("chase_done", int'(done), 1);
    chk("chase_done_tick", int'(tick_out), 1);
    chk("chase_last", int'(leds), 5'b00010);
    cyc(1);
    chk("chase_idle", int'(busy), 0);

    // COUNT, period 0, forever: wraps after 32 ticks.
    send(2'd3, 0, 0);
    cyc(1);
    chk("count_init", int'(leds), 0);
    cyc(31);
    chk("count_31", int'(leds), 31);
    cyc(1);
    chk("count_wrap", int'(leds), 0);
    chk("count_nodone", int'(done), 0);
    cyc(7);
    send(2'd0, 0, 0);
    cyc(1);

    // BLINK, period 2, forever, then OFF.
    send(2'd1, 2, 0);
    cyc(1);
    chk("blink_init", int'(leds), 0);
    cyc(3);
    chk("blink_on", int'(leds), 5'b11111);
    cyc(3);
    chk("blink_off", int'(leds), 0);
    cyc(3);
    chk("blink_on2", int'(leds), 5'b11111);
    send(2'd0, 0, 0);
    chk("off_leds", int'(leds), 0);
    chk("off_busy", int'(busy), 0);
    chk("off_nodone", int'(done), 0);
    cyc(2);

    // CHASE run interrupted by COUNT on a tick edge.
    send(2'd2, 3, 0);
    cyc(8);
    send(2'd3, 1, 3);
    chk("collide_notick", int'(tick_out), 0);
    chk("collide_leds", int'(leds), 5'b00010);
    chk("collide_ready", int'(cmd_ready), 0);
    cyc(1);
    chk("collide_load", int'(leds), 0);
    chk("collide_ready2", int'(cmd_ready), 1);
    cyc(6);
    chk("collide_done", int'(done), 1);
    chk("collide_leds3", int'(leds), 3);
    cyc(1);
    chk("collide_idle", int'(busy), 0);

    // Asynchronous reset mid-run.
    send(2'd2, 1, 4);
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_leds", int'(leds), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_tick", int'(tick_out), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_ready", int'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cyc(10);
    chk("arst_stay_idle", int'(busy), 0);
    chk("arst_stay_leds", int'(leds), 0);

    // cmd_valid held through LOAD while cmd_mode changes.
    cmd_valid  = 1'b1;
    cmd_mode   = 2'd1;
    cmd_period = 16'd1;
    cmd_steps  = 8'd0;
    @(negedge clk);
    chk("hold_load_ready", int'(cmd_ready), 0);
    cmd_mode   = 2'd2;
    cmd_period = 16'd2;
    cmd_steps  = 8'd2;
    @(negedge clk);
    chk("hold_run_leds", int'(leds), 0);
    chk("hold_run_ready", int'(cmd_ready), 1);
    @(negedge clk);
    chk("hold_second_load", int'(cmd_ready), 0);
    cmd_valid = 1'b0;
    cyc(1);
    chk("hold_chase_init", int'(leds), 5'b00001);
    cyc(6);
    chk("hold_done", int'(done), 1);
    chk("hold_leds", int'(leds), 5'b00100);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
